// File: rtl/apb_sram_ws.sv
// apb_sram_ws: APB4 slave in front of an inferred single-port SRAM.
// Supports byte strobes and a configurable read pipeline (RD_LATENCY), which
// adds RD_LATENCY-1 PREADY wait states to each read.
// Accesses to word indices >= DEPTH get PSLVERR and never touch memory.
// After reset the block zero-fills the whole array before it serves transfers.
// Optional feature macro APBSRAM_PARITY_EN adds even parity per byte, PSLVERR
// on a parity mismatch, and a saturating par_err_cnt output.
module apb_sram_ws #(
    parameter int unsigned APB_DWIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [19:0]             PADDR,
    input  logic [APB_DWIDTH-1:0]   PWDATA,
    input  logic [APB_DWIDTH/8-1:0] PSTRB,
    output logic [APB_DWIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    init_done
`ifdef APBSRAM_PARITY_EN
    ,
    output logic [7:0]              par_err_cnt
`endif
);

    localparam int unsigned NBYTES = APB_DWIDTH / 8;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BSHIFT = $clog2(NBYTES);
    localparam int unsigned IW     = 20 - BSHIFT;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PIPE_N = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
`ifdef APBSRAM_PARITY_EN
    localparam int unsigned SW     = APB_DWIDTH + NBYTES;
`else
    localparam int unsigned SW     = APB_DWIDTH;
`endif

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic [APB_DWIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [SW-1:0]           rd_pipe_q [PIPE_N];
    logic [SW-1:0]           rd_pipe_d [PIPE_N];

    logic [SW-1:0]           mem_q [DEPTH];
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic [SW-1:0]           mem_wword;
    logic [SW-1:0]           mem_wmask;
    logic [APB_DWIDTH-1:0]   wr_data;
    logic [NBYTES-1:0]       wr_strb;

    logic [IW-1:0]           idx;
    logic [AW-1:0]           idx_a;
    logic                    in_range;
    logic [SW-1:0]           rd_word;
    logic [SW-1:0]           rd_final;
    logic                    rd_launch;
    logic                    rd_done;
    logic                    rd_par_err;
    logic                    paddr_unused;

    // Word index decode and range check; byte-lane address bits are don't-care.
    assign idx          = PADDR[19:BSHIFT];
    assign idx_a        = idx[AW-1:0];
    assign in_range     = (32'(idx) < 32'(DEPTH));
    assign paddr_unused = ^PADDR;

    // SRAM read port and the word presented at the end of the read pipeline.
    assign rd_word  = mem_q[idx_a];
    assign rd_final = (RD_LATENCY == 1) ? rd_word : rd_pipe_q[PIPE_N-1];

`ifdef APBSRAM_PARITY_EN
    function automatic logic [NBYTES-1:0] byte_par(input logic [APB_DWIDTH-1:0] d);
        logic [NBYTES-1:0] p;
        for (int b = 0; b < NBYTES; b++) begin
            p[b] = ^d[8*b +: 8];
        end
        return p;
    endfunction

    assign rd_par_err = |(rd_final[SW-1:APB_DWIDTH] ^ byte_par(rd_final[APB_DWIDTH-1:0]));
`else
    assign rd_par_err = 1'b0;
`endif

    // Next-state, response and SRAM port control.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        prdata_d    = prdata_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        rd_launch   = 1'b0;
        rd_done     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = ptr_q;
        wr_data     = '0;
        wr_strb     = '1;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    ptr_d       = '0;
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (PSEL && PENABLE && PWRITE && pready_q) begin
                    // Completing write: commit on this edge if the index is valid.
                    if (in_range) begin
                        mem_we   = 1'b1;
                        mem_addr = idx_a;
                        wr_data  = PWDATA;
                        wr_strb  = PSTRB;
                    end
                end else if (PSEL && !pready_q) begin
                    // New transfer (or one held off during INIT).
                    if (!in_range) begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        if (!PWRITE) begin
                            prdata_d = '0;
                        end
                    end else if (PWRITE) begin
                        pready_d = 1'b1;
                    end else begin
                        rd_launch = 1'b1;
                        cnt_d     = CNT_W'(RD_LATENCY - 1);
                        if (RD_LATENCY == 1) begin
                            state_d  = ST_RESP;
                            pready_d = 1'b1;
                            rd_done  = 1'b1;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_RESP;
                    pready_d = 1'b1;
                    rd_done  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rd_done) begin
            prdata_d  = rd_final[APB_DWIDTH-1:0];
            pslverr_d = rd_par_err;
        end
    end

    // Read pipeline: stage 0 captures the SRAM word on launch, later stages shift.
    always_comb begin
        rd_pipe_d[0] = rd_launch ? rd_word : rd_pipe_q[0];
        for (int i = 1; i < PIPE_N; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    // Byte-masked write word; parity bits follow their data byte strobe.
    always_comb begin
        mem_wword = '0;
        mem_wmask = '0;
        mem_wword[APB_DWIDTH-1:0] = wr_data;
        for (int b = 0; b < NBYTES; b++) begin
            mem_wmask[8*b +: 8] = {8{wr_strb[b]}};
`ifdef APBSRAM_PARITY_EN
            mem_wword[APB_DWIDTH+b] = ^wr_data[8*b +: 8];
            mem_wmask[APB_DWIDTH+b] = wr_strb[b];
`endif
        end
    end

    // SRAM array; a write coinciding with reset is dropped.
    always_ff @(posedge PCLK) begin
        if (mem_we && !PRESET) begin
            mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_wmask) | (mem_wword & mem_wmask);
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            for (int i = 0; i < PIPE_N; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            for (int i = 0; i < PIPE_N; i++) begin
                rd_pipe_q[i] <= rd_pipe_d[i];
            end
        end
    end

`ifdef APBSRAM_PARITY_EN
    logic [7:0] par_cnt_q, par_cnt_d;

    // Saturating count of reads that completed with a parity mismatch.
    always_comb begin
        par_cnt_d = par_cnt_q;
        if (rd_done && rd_par_err && (par_cnt_q != 8'hFF)) begin
            par_cnt_d = par_cnt_q + 8'd1;
        end
    end

    // Parity error counter register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            par_cnt_q <= '0;
        end else begin
            par_cnt_q <= par_cnt_d;
        end
    end

    assign par_err_cnt = par_cnt_q;
`endif

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_apb_sram_ws.sv
// Bench for apb_sram_ws: two instances (RD_LATENCY 1 and 3) on one APB master,
// with random transfers checked against a word-array reference model.
`timescale 1ns/1ps
module tb_apb_sram_ws;

    localparam int unsigned DW         = 32;
    localparam int unsigned DEPTH      = 512;
    localparam int          WAIT_LIMIT = 2000;

    logic        clk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [19:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        tgt = 1'b0;

    logic        psel_a, psel_b;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b, init_done_a, init_done_b;
`ifdef APBSRAM_PARITY_EN
    logic [7:0]  par_cnt_a, par_cnt_b;
`endif

    logic [31:0] prdata_m;
    logic        pready_m, pslverr_m;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat [2] = '{1, 3};
    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    assign psel_a    = psel & ~tgt;
    assign psel_b    = psel &  tgt;
    assign prdata_m  = tgt ? prdata_b  : prdata_a;
    assign pready_m  = tgt ? pready_b  : pready_a;
    assign pslverr_m = tgt ? pslverr_b : pslverr_a;

    apb_sram_ws #(.APB_DWIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(1)) u_dut_a (
        .PCLK      (clk),
        .PRESET    (preset),
        .PSEL      (psel_a),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PSTRB     (pstrb),
        .PRDATA    (prdata_a),
        .PREADY    (pready_a),
        .PSLVERR   (pslverr_a),
        .init_done (init_done_a)
`ifdef APBSRAM_PARITY_EN
        ,
        .par_err_cnt (par_cnt_a)
`endif
    );

    apb_sram_ws #(.APB_DWIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(3)) u_dut_b (
        .PCLK      (clk),
        .PRESET    (preset),
        .PSEL      (psel_b),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PSTRB     (pstrb),
        .PRDATA    (prdata_b),
        .PREADY    (pready_b),
        .PSLVERR   (pslverr_b),
        .init_done (init_done_b)
`ifdef APBSRAM_PARITY_EN
        ,
        .par_err_cnt (par_cnt_b)
`endif
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Neither slave may signal completion while its zero-fill is running.
    always @(negedge clk) begin
        if (!preset && !init_done_a) chk_eq("pready_a_in_init", 32'(pready_a), 32'd0);
        if (!preset && !init_done_b) chk_eq("pready_b_in_init", 32'(pready_b), 32'd0);
    end

    task automatic model_clear();
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < int'(DEPTH); i++) model_mem[t][i] = '0;
            last_rd[t] = '0;
        end
    endtask

    // One APB transfer; called and returns #1 after a rising edge.
    task automatic apb_xfer(input int t, input logic wr, input logic [19:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic err, output int waits);
        tgt     = t[0];
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        @(posedge clk); #1;
        penable = 1'b1;
        waits   = 0;
        while (!pready_m && waits < WAIT_LIMIT) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!pready_m) chk_eq("pready_timeout", 32'(pready_m), 32'd1);
        rd  = prdata_m;
        err = pslverr_m;
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Runs a transfer and checks it against the reference model.
    task automatic xfer_chk(input int t, input logic wr, input logic [19:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd);
        logic        err;
        int          waits;
        int unsigned wi;
        logic        oor;
        logic [31:0] exp;
        wi  = 32'(a) >> 2;
        oor = (wi >= DEPTH);
        apb_xfer(t, wr, a, wd, st, rd, err, waits);
        chk_eq($sformatf("waits t%0d %s a=%0h", t, wr ? "wr" : "rd", a), 32'(waits),
               (wr || oor) ? 32'd0 : 32'(lat[t] - 1));
        chk_eq($sformatf("pslverr t%0d a=%0h", t, a), 32'(err), 32'(oor));
        if (!wr) begin
            exp = oor ? 32'd0 : model_mem[t][wi];
            chk_eq($sformatf("rdata t%0d a=%0h", t, a), rd, exp);
            last_rd[t] = exp;
        end else if (!oor) begin
            chk_eq($sformatf("prdata_hold t%0d a=%0h", t, a), rd, last_rd[t]);
            for (int b = 0; b < 4; b++) begin
                if (st[b]) model_mem[t][wi][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          waits;
        int          n;
        int          sel;
        int unsigned wi;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_prdata_a",   prdata_a,          32'd0);
        chk_eq("rst_pready_a",   32'(pready_a),     32'd0);
        chk_eq("rst_pslverr_a",  32'(pslverr_a),    32'd0);
        chk_eq("rst_init_done_a", 32'(init_done_a), 32'd0);
        chk_eq("rst_prdata_b",   prdata_b,          32'd0);
        chk_eq("rst_init_done_b", 32'(init_done_b), 32'd0);

        // Read issued during zero-fill waits exactly DEPTH cycles on the latency-1 slave.
        preset = 1'b0;
        apb_xfer(0, 1'b0, 20'h7FC, 32'h0, 4'h0, rd, err, waits);
        chk_eq("init_read_waits", 32'(waits), 32'(DEPTH));
        chk_eq("init_read_data",  rd,  32'd0);
        chk_eq("init_read_err",   32'(err), 32'd0);
        chk_eq("init_done_a",     32'(init_done_a), 32'd1);
        chk_eq("init_done_b",     32'(init_done_b), 32'd1);

        // Byte strobes, zero strobe and out-of-range on both latencies.
        for (int t = 0; t < 2; t++) begin
            xfer_chk(t, 1'b1, 20'h10, 32'hAABBCCDD, 4'hF, rd);
            xfer_chk(t, 1'b1, 20'h10, 32'h11223344, 4'b0101, rd);
            xfer_chk(t, 1'b0, 20'h10, 32'h0, 4'h0, rd);
            chk_eq($sformatf("strobe_const t%0d", t), rd, 32'hAA22CC44);
            xfer_chk(t, 1'b1, 20'h10, 32'h55667788, 4'h0, rd);
            xfer_chk(t, 1'b0, 20'h10, 32'h0, 4'h0, rd);
            xfer_chk(t, 1'b1, 20'h800, 32'hDEADBEEF, 4'hF, rd);
            xfer_chk(t, 1'b0, 20'h800, 32'h0, 4'h0, rd);
            xfer_chk(t, 1'b0, 20'h000, 32'h0, 4'h0, rd);
            xfer_chk(t, 1'b0, 20'h7FC, 32'h0, 4'h0, rd);
        end

        // Random mix of reads, writes and out-of-range accesses.
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      wi = $urandom_range(0, 15);
            else if (sel == 7) wi = $urandom_range(DEPTH - 16, DEPTH - 1);
            else if (sel == 8) wi = $urandom_range(DEPTH, DEPTH + 127);
            else               wi = $urandom_range(DEPTH, 32'h3FFFF);
            xfer_chk(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     20'((wi << 2) | $urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), rd);
        end

        // Reset while the latency-3 slave is in its wait states.
        xfer_chk(1, 1'b1, 20'h20, 32'h5A5A1234, 4'hF, rd);
        xfer_chk(1, 1'b0, 20'h20, 32'h0, 4'h0, rd);
        tgt     = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 20'h20;
        @(posedge clk); #1;
        penable = 1'b1;
        chk_eq("rdwait_pready_b", 32'(pready_b), 32'd0);
        preset = 1'b1;
        @(posedge clk); #1;
        chk_eq("midrst_prdata_b",   prdata_b,          32'd0);
        chk_eq("midrst_pready_b",   32'(pready_b),     32'd0);
        chk_eq("midrst_pslverr_b",  32'(pslverr_b),    32'd0);
        chk_eq("midrst_init_done_b", 32'(init_done_b), 32'd0);
        chk_eq("midrst_init_done_a", 32'(init_done_a), 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        preset  = 1'b0;
        n = 0;
        while (!(init_done_a && init_done_b) && n < WAIT_LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("refill_cycles", 32'(n), 32'(DEPTH));
        model_clear();
        for (int t = 0; t < 2; t++) begin
            xfer_chk(t, 1'b0, 20'h10, 32'h0, 4'h0, rd);
            xfer_chk(t, 1'b0, 20'h20, 32'h0, 4'h0, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
